// File: rtl/btn_pkg.sv
// -----------------------------------------------------------------------------
// btn_pkg
// Shared constants and types for the push-button debounce stage.
//   DEBOUNCE_CYCLES_DEFAULT : hold time in clk cycles used on the board
//   DEBOUNCE_CYCLES_SIM     : short hold time used in simulation
//   btn_state_t             : per-channel debounced state (RELEASED/PRESSED)
// -----------------------------------------------------------------------------
package btn_pkg;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 50000;
    localparam int DEBOUNCE_CYCLES_SIM     = 4;

    typedef enum logic {
        BTN_RELEASED = 1'b0,
        BTN_PRESSED  = 1'b1
    } btn_state_t;

endpackage

// File: rtl/btn_debounce_ch.sv
// -----------------------------------------------------------------------------
// btn_debounce_ch
// One debounce channel: two-flop synchronizer, disagreement counter, stable
// level (two-state machine), registered press/release pulses and a toggle
// latch that flips on every accepted press.
// Ports:
//   clk           in   system clock
//   reset         in   synchronous active-high reset
//   raw           in   asynchronous button input, 1 = pressed
//   level         out  debounced level (1 = PRESSED state)
//   press_pulse   out  one-cycle pulse on an accepted 0->1 transition
//   release_pulse out  one-cycle pulse on an accepted 1->0 transition
//   toggle        out  flips on every accepted press
// DEBOUNCE_CYCLES must be >= 2.
// -----------------------------------------------------------------------------
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic toggle
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1;
    logic          s;
    logic [CW-1:0] cnt;
    btn_state_t    state;

    // The debounced level is the state itself.
    assign level = (state == BTN_PRESSED);

    always_ff @(posedge clk) begin
        if (reset) begin
            s1            <= 1'b0;
            s             <= 1'b0;
            cnt           <= '0;
            state         <= BTN_RELEASED;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            toggle        <= 1'b0;
        end else begin
            s1            <= raw;
            s             <= s1;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;

            if (s == level) begin
                // Agreement discards any partial count, so a bounce back
                // restarts the whole window.
                cnt <= '0;
            end else if (cnt < CNT_LAST) begin
                cnt <= cnt + CW'(1);
            end else begin
                // DEBOUNCE_CYCLES consecutive disagreeing samples: accept s.
                cnt           <= '0;
                state         <= s ? BTN_PRESSED : BTN_RELEASED;
                press_pulse   <= s;
                release_pulse <= ~s;
                if (s) begin
                    toggle <= ~toggle;
                end
            end
        end
    end

endmodule

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Debounce and edge-detect stage for the board push-buttons. Optionally
// inverts active-low inputs so "pressed" is 1 internally, then runs one
// independent btn_debounce_ch per button.
// Ports:
//   clk          in   system clock (only clock)
//   reset        in   synchronous active-high reset
//   btn_raw      in   [N_BTN] asynchronous button inputs
//   btn_level    out  [N_BTN] debounced level, 1 = pressed
//   btn_press    out  [N_BTN] one-cycle pulse per accepted press
//   btn_release  out  [N_BTN] one-cycle pulse per accepted release
//   btn_toggle   out  [N_BTN] flips on every accepted press
// -----------------------------------------------------------------------------
module btn_debounce
    import btn_pkg::*;
#(
    parameter int N_BTN           = 2,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter bit BTN_ACTIVE_LOW  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_toggle
);

    logic [N_BTN-1:0] btn_in;

    assign btn_in = BTN_ACTIVE_LOW ? ~btn_raw : btn_raw;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk          (clk),
            .reset        (reset),
            .raw          (btn_in[i]),
            .level        (btn_level[i]),
            .press_pulse  (btn_press[i]),
            .release_pulse(btn_release[i]),
            .toggle       (btn_toggle[i])
        );
    end

endmodule

// File: tb/tb_btn_debounce.sv
// -----------------------------------------------------------------------------
// tb_btn_debounce
// Self-checking bench for btn_debounce (N_BTN = 2, DEBOUNCE_CYCLES = 4).
// The reference model keeps the last DEBOUNCE_CYCLES synchronized samples of
// each channel and accepts a new level when all of them disagree with the
// current level.
// -----------------------------------------------------------------------------
module tb_btn_debounce;
    import btn_pkg::*;

    localparam int D = DEBOUNCE_CYCLES_SIM;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] btn_raw = 2'b00;
    logic [1:0] btn_level;
    logic [1:0] btn_press;
    logic [1:0] btn_release;
    logic [1:0] btn_toggle;

    always #5 clk = ~clk;

    btn_debounce #(
        .N_BTN          (2),
        .DEBOUNCE_CYCLES(D),
        .BTN_ACTIVE_LOW (1'b0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_toggle (btn_toggle)
    );

    // ---------------- scoreboard state ----------------
    int checks   = 0;
    int failures = 0;
    int edge_n   = 0;

    int n_press[2];
    int n_rel[2];
    int last_press[2];
    int last_rel[2];
    bit tog_at_press[2];

    // reference model
    bit m_s1[2];
    bit m_s[2];
    bit m_lvl[2];
    bit m_press[2];
    bit m_rel[2];
    bit m_tog[2];
    bit win[2][D];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s edge=%0d got=%0h exp=%0h", tag, edge_n, got, exp);
        end
    endtask

    function automatic void model_edge(input logic [1:0] r, input logic rs);
        for (int ch = 0; ch < 2; ch++) begin
            if (rs) begin
                m_s1[ch] = 1'b0; m_s[ch] = 1'b0; m_lvl[ch] = 1'b0;
                m_press[ch] = 1'b0; m_rel[ch] = 1'b0; m_tog[ch] = 1'b0;
                for (int j = 0; j < D; j++) win[ch][j] = 1'b0;
            end else begin
                bit smp;
                bit all_diff;
                smp = m_s[ch];
                for (int j = D - 1; j > 0; j--) win[ch][j] = win[ch][j-1];
                win[ch][0] = smp;
                all_diff = 1'b1;
                for (int j = 0; j < D; j++) if (win[ch][j] == m_lvl[ch]) all_diff = 1'b0;
                m_press[ch] = 1'b0;
                m_rel[ch]   = 1'b0;
                if (all_diff) begin
                    m_lvl[ch]   = smp;
                    m_press[ch] = smp;
                    m_rel[ch]   = !smp;
                    if (smp) m_tog[ch] = !m_tog[ch];
                end
                m_s[ch]  = m_s1[ch];
                m_s1[ch] = r[ch];
            end
        end
    endfunction

    // ---------------- driver ----------------
    task automatic step(input logic [1:0] r, input logic rs);
        btn_raw = r;
        reset   = rs;
        @(posedge clk);
        model_edge(r, rs);
        #1;
        edge_n++;
        check("level",   32'(btn_level),   32'({m_lvl[1], m_lvl[0]}));
        check("press",   32'(btn_press),   32'({m_press[1], m_press[0]}));
        check("release", 32'(btn_release), 32'({m_rel[1], m_rel[0]}));
        check("toggle",  32'(btn_toggle),  32'({m_tog[1], m_tog[0]}));
        check("excl",    32'(btn_press & btn_release), 32'(0));
        for (int ch = 0; ch < 2; ch++) begin
            if (btn_press[ch]) begin
                n_press[ch]++;
                last_press[ch]   = edge_n;
                tog_at_press[ch] = btn_toggle[ch];
            end
            if (btn_release[ch]) begin
                n_rel[ch]++;
                last_rel[ch] = edge_n;
            end
        end
    endtask

    task automatic clear_counts();
        for (int ch = 0; ch < 2; ch++) begin
            n_press[ch] = 0; n_rel[ch] = 0; last_press[ch] = -1; last_rel[ch] = -1;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin : main
        int rise_edge;
        int fall_edge;
        int rst_edge;
        logic [1:0] hold;
        bit pat[10];

        model_edge(2'b00, 1'b1);
        clear_counts();

        // 1. Reset with both buttons held
        for (int i = 0; i < 3; i++) begin
            step(2'b11, 1'b1);
            check("t1_rst_out", 32'({btn_level, btn_press, btn_release, btn_toggle}), 32'(0));
        end
        rst_edge = edge_n;
        for (int i = 1; i <= 6; i++) begin
            step(2'b11, 1'b0);
            if (i == 5) check("t1_no_early_press", 32'(btn_press), 32'(0));
        end
        check("t1_press_at6", 32'(btn_press), 32'(2'b11));
        check("t1_level_at6", 32'(btn_level), 32'(2'b11));
        check("t1_toggle_at6", 32'(btn_toggle), 32'(2'b11));
        check("t1_press_edge", 32'(last_press[0] - rst_edge), 32'(6));
        step(2'b11, 1'b0);
        check("t1_press_1cyc", 32'(btn_press), 32'(0));
        repeat (10) step(2'b00, 1'b0);

        // 2. Clean press/release on channel 0 from a fresh reset
        step(2'b00, 1'b1);
        clear_counts();
        rise_edge = edge_n + 1;
        repeat (10) step(2'b01, 1'b0);
        fall_edge = edge_n + 1;
        repeat (10) step(2'b00, 1'b0);
        check("t2_npress", 32'(n_press[0]), 32'(1));
        check("t2_press_edge", 32'(last_press[0] - rise_edge), 32'(5));
        check("t2_nrel", 32'(n_rel[0]), 32'(1));
        check("t2_rel_edge", 32'(last_rel[0] - fall_edge), 32'(5));
        check("t2_toggle0", 32'(btn_toggle[0]), 32'(1));
        check("t2_ch1_quiet", 32'({n_press[1], n_rel[1]}), 32'(0));
        check("t2_ch1_out", 32'({btn_level[1], btn_toggle[1]}), 32'(0));

        // 3. Bounce on channel 0
        clear_counts();
        pat = '{1, 0, 1, 1, 0, 1, 1, 1, 1, 1};
        for (int i = 0; i < 10; i++) step({1'b0, pat[i]}, 1'b0);
        repeat (6) step(2'b01, 1'b0);
        check("t3_npress", 32'(n_press[0]), 32'(1));
        check("t3_nrel", 32'(n_rel[0]), 32'(0));
        check("t3_level", 32'(btn_level[0]), 32'(1));
        repeat (10) step(2'b00, 1'b0);

        // 4. Glitches of 1, 2, 3 cycles on channel 1
        clear_counts();
        for (int len = 1; len <= 3; len++) begin
            repeat (len) step(2'b10, 1'b0);
            repeat (6) step(2'b00, 1'b0);
            check("t4_level1", 32'(btn_level[1]), 32'(0));
        end
        check("t4_npress1", 32'(n_press[1]), 32'(0));
        check("t4_nrel1", 32'(n_rel[1]), 32'(0));

        // 5. Toggle sequence on channel 0 from a fresh reset
        step(2'b00, 1'b1);
        clear_counts();
        for (int k = 0; k < 3; k++) begin
            repeat (8) step(2'b01, 1'b0);
            check("t5_npress", 32'(n_press[0]), 32'(k + 1));
            check("t5_tog_at_press", 32'(tog_at_press[0]), 32'((k % 2) == 0));
            repeat (8) step(2'b00, 1'b0);
        end
        check("t5_toggle_end", 32'(btn_toggle[0]), 32'(1));

        // 6. Reset mid-count
        clear_counts();
        repeat (3) step(2'b01, 1'b0);
        check("t6_no_early", 32'(n_press[0]), 32'(0));
        step(2'b01, 1'b1);
        rst_edge = edge_n;
        check("t6_no_press_rst", 32'(n_press[0]), 32'(0));
        repeat (8) step(2'b01, 1'b0);
        check("t6_npress", 32'(n_press[0]), 32'(1));
        check("t6_press_edge", 32'(last_press[0] - rst_edge), 32'(6));
        check("t6_toggle", 32'(btn_toggle[0]), 32'(1));

        // Randomized bouncing, holding and occasional resets on both channels
        hold = 2'b00;
        for (int i = 0; i < 800; i++) begin
            logic [1:0] drv;
            for (int ch = 0; ch < 2; ch++)
                if ($urandom_range(0, 9) < 2) hold[ch] = ~hold[ch];
            drv = hold;
            if ($urandom_range(0, 7) == 0) drv[$urandom_range(0, 1)] ^= 1'b1;
            step(drv, ($urandom_range(0, 199) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/btn_debounce.md
# btn_debounce

Debounce and edge-detect stage that sits between the board push-buttons (`BTN`) and the letter/segment logic that drives `pio`. It synchronises each raw button into the `clk` domain and filters contact bounce. Per button it outputs a clean level, one-cycle press and release pulses, and a press-toggled latch. The downstream letter logic uses the clean level or the toggle latch in place of the raw `BTN` bit.

## Interface
- `N_BTN`, 2: number of button channels.
- `DEBOUNCE_CYCLES`, 50000: cycles an input must hold a new value before it is accepted. Must be ≥ 2.
- `BTN_ACTIVE_LOW`, 0: when 1, raw inputs are inverted at the input so "pressed" is always 1 internally.
- `clk`  in  1  system clock. The only clock.
- `reset`  in  1  synchronous, active-high reset.
- `btn_raw`  in  N_BTN  asynchronous button inputs.
- `btn_level`  out  N_BTN  debounced level, 1 = pressed.
- `btn_press`  out  N_BTN  one-cycle pulse on an accepted 0→1 transition.
- `btn_release`  out  N_BTN  one-cycle pulse on an accepted 1→0 transition.
- `btn_toggle`  out  N_BTN  flips on every press.

## Operation
All channels are identical and independent. Each channel has the following state:
- **Two-flop synchronizer:** `s1` ← `btn_raw` (after optional inversion), then `s` ← `s1`.
- **Counter `cnt`:** width `$clog2(DEBOUNCE_CYCLES)`.
- **Stable level:** `lvl`, driven out as `btn_level`.
- **Registered pulses and toggle:** `btn_press`, `btn_release`, `btn_toggle`.

Per-cycle update rules (the pulse registers default to 0 every cycle):
- **`s == lvl`:** `cnt` ← 0. Any partial count is discarded, so a bounce back restarts the window.
- **`s != lvl` and `cnt < DEBOUNCE_CYCLES-1`:** `cnt` ← `cnt`+1.
- **`s != lvl` and `cnt == DEBOUNCE_CYCLES-1`:** on the same edge:
  - `lvl` ← `s`
  - `cnt` ← 0
  - `btn_press` ← `s`
  - `btn_release` ← !`s`
  - if `s` = 1, `btn_toggle` ← !`btn_toggle`

Effectively this is a two-state machine per channel, RELEASED (`lvl` = 0) and PRESSED (`lvl` = 1). A transition fires only after `DEBOUNCE_CYCLES` consecutive cycles of disagreement between `s` and `lvl`.

## Timing
- **Reset values:** every flop is 0 — `s1`, `s`, `cnt`, `btn_level`, `btn_press`, `btn_release`, `btn_toggle`.
- **Latency:** `btn_raw` changes and stays stable before edge k.
  - `s` reflects the new value after edge k+1.
  - `btn_level` and the pulse outputs update at edge k+1+`DEBOUNCE_CYCLES`, i.e. `DEBOUNCE_CYCLES`+2 edges after the change.
- **Pulse width:** `btn_press` and `btn_release` are exactly one cycle wide. They never assert in the same cycle on one channel. They are not asserted during or in the first cycle after reset.
- **Short glitches:** a glitch shorter than `DEBOUNCE_CYCLES` cycles at `s` produces no output change.
- **Counter saturation:** `cnt` never exceeds `DEBOUNCE_CYCLES-1` and never wraps.
- **Reset mid-count:** the count is discarded. If the button is still held after reset deasserts, a fresh press is detected `DEBOUNCE_CYCLES`+2 edges later, with a `btn_press` pulse and a toggle flip.
- **Simultaneous events:** different channels may pulse in the same cycle. There is no interaction between channels.

## Structure
- **Shared package `btn_pkg`:** holds `DEBOUNCE_CYCLES_DEFAULT` and the simulation value `DEBOUNCE_CYCLES_SIM` = 4. Board and bench use it.
- **Sub-module `btn_debounce_ch`:** one channel containing synchronizer, counter, level, pulses and toggle. It is instantiated `N_BTN` times with a generate loop.
- **Top:** `btn_debounce` contains only the input inversion and the generate loop.

## Test plan
All scenarios use `DEBOUNCE_CYCLES` = 4 and `N_BTN` = 2.

1. **Reset:** assert `reset` for 3 cycles with `btn_raw` = 2'b11 → all outputs are 0 throughout. After deassertion, `btn_level` = 2'b11 and `btn_press` = 2'b11 for one cycle exactly 6 edges later, with `btn_toggle` = 2'b11.
2. **Clean press/release:** `btn_raw[0]` 0→1 held 10 cycles, then 1→0 held 10 cycles.
   - `btn_press[0]` pulses once, 6 edges after the rise.
   - `btn_release[0]` pulses once, 6 edges after the fall.
   - `btn_toggle[0]` = 1 at the end.
   - Channel 1 outputs stay 0.
3. **Bounce:** `btn_raw[0]` pattern 1,0,1,1,0,1,1,1,1,1… → no output until 4 consecutive synchronized 1s. Then exactly one `btn_press` pulse.
4. **Glitch rejection:** pulses of 1, 2 and 3 cycles on `btn_raw[1]` → `btn_level[1]` stays 0 and no pulses occur.
5. **Toggle sequence:** three full press/release cycles on channel 0 → `btn_toggle[0]` goes 1, 0, 1. Each flip coincides with `btn_press[0]`.
6. **Reset mid-count:** raise `btn_raw[0]`, then assert `reset` 3 edges later for one cycle while holding the button → no pulse before reset. After reset, the press fires 6 edges after deassertion.
